// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin drain of N FWFT FIFOs into one registered valid/ready stream tagged with source index
module fifo_rr_arbiter #(
  parameter int N_IN = 4,
  parameter int WIDTH = 32,
  parameter int MAX_BURST = 1,
  localparam int IDX_W = $clog2(N_IN),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [N_IN-1:0]       in_empty,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDX_W-1:0]      out_src
);
  logic [IDX_W-1:0] last_grant, rot, idx, g;
  logic [BW-1:0] burst_cnt;
  logic [WIDTH-1:0] g_data;
  logic load, any, hold, grant;
  // Grant selection: keep the burst source or rotate to the next non-empty index; pop only when the register can take the word
  always_comb begin
    rot = last_grant;
    idx = last_grant;
    for (int k = N_IN; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % N_IN);
      rot = !in_empty[idx] ? idx : rot;
    end
    hold = !in_empty[last_grant] && burst_cnt < BW'(MAX_BURST - 1);
    g = hold ? last_grant : rot;
    load = !out_valid | out_ready;
    any = ~&in_empty;
    grant = load & any & !srst;
    in_rd_en = grant ? N_IN'(1) << g : '0;
    g_data = '0;
    for (int i = 0; i < N_IN; i++)
      g_data = (g == IDX_W'(i)) ? in_data[i*WIDTH +: WIDTH] : g_data;
  end
  // Output register and arbitration state; refilled whenever it is empty or being drained
  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      last_grant <= IDX_W'(N_IN - 1);
      burst_cnt <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= g_data;
        out_src <= g;
        last_grant <= g;
        burst_cnt <= hold ? burst_cnt + 1'b1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: FIFO models plus a pop-order scoreboard around two arbiter instances (pure RR and burst 2)
module tb_fifo_rr_arbiter;
  logic clk, srst;
  logic [3:0] in_empty, in_rd_en, b_empty, b_rd_en;
  logic [127:0] in_data, b_data;
  logic out_valid, out_ready, b_valid, b_ready;
  logic [31:0] out_data, b_out_data;
  logic [1:0] out_src, b_src;
  logic [31:0] q[4][$];
  logic [33:0] exp_q[$];
  logic [1:0] srcs[$];
  logic [3:0] last_rd;
  int n_vec = 0, n_err = 0;

  fifo_rr_arbiter #(.N_IN(4), .WIDTH(32), .MAX_BURST(1)) dut (
    .clk(clk), .srst(srst), .in_empty(in_empty), .in_data(in_data), .in_rd_en(in_rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src));

  fifo_rr_arbiter #(.N_IN(4), .WIDTH(32), .MAX_BURST(2)) dut_b (
    .clk(clk), .srst(srst), .in_empty(b_empty), .in_data(b_data), .in_rd_en(b_rd_en),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_out_data), .out_src(b_src));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_empty[i] = q[i].size() == 0;
      in_data[i*32 +: 32] = q[i].size() == 0 ? 32'h0 : q[i][0];
    end
  endtask

  task automatic tick();
    logic [3:0] rd;
    logic [33:0] e;
    #1;
    rd = in_rd_en;
    last_rd = rd;
    chk("no_pop_empty", 64'(rd & in_empty), 64'(0));
    chk("rd_onehot0", 64'($onehot0(rd)), 64'(1));
    if (srst) chk("rd_in_reset", 64'(rd), 64'(0));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 64'({out_src, out_data}), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("sb_word", 64'({out_src, out_data}), 64'(e));
      end
      srcs.push_back(out_src);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (rd[i]) begin
        exp_q.push_back({2'(i), q[i][0]});
        void'(q[i].pop_front());
      end
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((out_valid || q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(out_valid), 64'(0));
  endtask

  initial begin
    srst = 1'b1;
    out_ready = 1'b1;
    b_ready = 1'b1;
    b_empty = 4'b1111;
    b_data = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) q[i].push_back({8'(i + 1), 16'h0, 8'(k)});
    drive();
    // T1: reset with everything non-empty
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_src", 64'(out_src), 64'(0));
    srst = 1'b0;
    tick();
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_first_src", 64'(out_src), 64'(0));
    // T2: round robin, one pop per cycle
    srcs.delete();
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t2_one_rd", 64'($countones(last_rd)), 64'(1));
    end
    chk("t2_count", 64'(srcs.size()), 64'(6));
    for (int j = 0; j < 6; j++) chk("t2_src", 64'(srcs[j]), 64'(j % 4));
    // T6: one-cycle reset mid-stream
    srst = 1'b1;
    tick();
    chk("t6_valid", 64'(out_valid), 64'(0));
    srst = 1'b0;
    tick();
    chk("t6_valid_again", 64'(out_valid), 64'(1));
    chk("t6_src", 64'(out_src), 64'(0));
    drain();
    // T3: backpressure on a held word, then no-gap resume
    q[1].push_back(32'hA5A5A5A5);
    drive();
    tick();
    q[2].push_back(32'hB0B0B0B0);
    q[0].push_back(32'hC0C0C0C0);
    drive();
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t3_rd", 64'(last_rd), 64'(0));
      chk("t3_hold_data", 64'(out_data), 64'(32'hA5A5A5A5));
      chk("t3_hold_src", 64'(out_src), 64'(1));
    end
    out_ready = 1'b1;
    tick();
    chk("t3_next_valid", 64'(out_valid), 64'(1));
    chk("t3_next_src", 64'(out_src), 64'(2));
    tick();
    chk("t3_wrap_src", 64'(out_src), 64'(0));
    tick();
    chk("t3_idle", 64'(out_valid), 64'(0));
    // T4: single source stream
    q[2].push_back(32'h11);
    q[2].push_back(32'h22);
    q[2].push_back(32'h33);
    drive();
    tick();
    chk("t4_d0", 64'({out_valid, out_src, out_data}), 64'({1'b1, 2'd2, 32'h11}));
    tick();
    chk("t4_d1", 64'({out_valid, out_src, out_data}), 64'({1'b1, 2'd2, 32'h22}));
    tick();
    chk("t4_d2", 64'({out_valid, out_src, out_data}), 64'({1'b1, 2'd2, 32'h33}));
    tick();
    chk("t4_idle", 64'(out_valid), 64'(0));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    // T5: burst of 2 on the second instance, inputs 0 and 1 always non-empty
    b_empty = 4'b1100;
    for (int i = 0; i < 4; i++) b_data[i*32 +: 32] = 32'hB0 + 32'(i);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t5_src", 64'(b_src), 64'((j / 2) % 2));
      chk("t5_data", 64'(b_out_data), 64'(32'hB0 + 32'((j / 2) % 2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
